// File: rtl/seq_div.sv
// Iterative restoring divider: 2*DW-bit dividend by DW-bit divisor, one quotient bit per cycle.
// Valid/ready handshakes on both the operand and result sides.
module seq_div #(
    parameter int unsigned DW = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   quotient,
    output logic [DW-1:0]     remainder,
    output logic              div_by_zero,
    output logic              busy
);

    localparam int unsigned CW = $clog2(2*DW);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [2*DW-1:0]  dvd_sh;
    logic [2*DW-1:0]  quo;
    logic [DW-1:0]    dsr;
    logic [DW:0]      prem;
    logic [DW:0]      trial;
    logic [DW:0]      prem_nxt;
    logic             q_bit;
    logic [CW-1:0]    cnt;

    // A zero divisor needs no special case: every trial passes, giving all-ones
    // quotient and the dividend's low bits left in the partial remainder.
    always_comb begin
        trial    = {prem[DW-1:0], dvd_sh[2*DW-1]};
        q_bit    = (trial >= {1'b0, dsr});
        prem_nxt = q_bit ? (trial - {1'b0, dsr}) : trial;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = CALC;
            CALC:    if (cnt == '0)   state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_sh      <= '0;
            quo         <= '0;
            dsr         <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_sh <= dividend;
                        dsr    <= divisor;
                        prem   <= '0;
                        quo    <= '0;
                        cnt    <= CW'(2*DW-1);
                    end
                end
                CALC: begin
                    dvd_sh <= dvd_sh << 1;
                    prem   <= prem_nxt;
                    quo    <= {quo[2*DW-2:0], q_bit};
                    cnt    <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient    <= {quo[2*DW-2:0], q_bit};
                        remainder   <= prem_nxt[DW-1:0];
                        div_by_zero <= (dsr == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
